// File: rtl/flag_loader.sv
// flag_loader: byte-serial front end for the 256-bit combinational flag checker.
// Bytes arrive MSB-first over a valid/ready handshake and are shifted into
// the checker input word. Once a frame ends, the word is frozen for SETTLE
// cycles so the checker's ripple network can resolve before `wrong` is
// sampled. The pass/fail result is then held until the host acknowledges it.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_LOAD   | accepting bytes; in_ready high; frame ends on in_last or NBYTES
// S_SETTLE | flag frozen; settle down-counter runs to terminal count 1
// S_REPORT | done/pass/len_err held until ack clears them and returns to load

module flag_loader #(
  parameter int NBYTES = 32,
  parameter int SETTLE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic [8*NBYTES-1:0]   flag,
  input  logic [8*NBYTES-1:0]   wrong,
  output logic                  done,
  output logic                  pass,
  output logic                  len_err,
  input  logic                  ack
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES + 1);
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SETTLE = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [CW-1:0]   byte_cnt;
  logic [CW-1:0]   byte_cnt_inc;
  logic [SW-1:0]   settle_cnt;

  logic            accept;
  logic            full_count;
  logic            frame_end;
  logic            len_bad;
  logic            settle_tc;
  logic            release_result;

  // Handshake and frame-termination decode.
  assign in_ready       = (state == S_LOAD);
  assign accept         = in_valid && in_ready;
  assign byte_cnt_inc   = byte_cnt + CW'(1);
  assign full_count     = (byte_cnt_inc == CW'(NBYTES));
  assign frame_end      = accept && (in_last || full_count);
  // Only a frame that ends with in_last on exactly the NBYTES-th byte is well formed.
  assign len_bad        = !(full_count && in_last);
  assign settle_tc      = (state == S_SETTLE) && (settle_cnt == SW'(1));
  assign release_result = (state == S_REPORT) && ack;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; ack outside REPORT falls through untouched.
  always_comb begin
    state_next = state;
    case (state)
      S_LOAD: begin
        if (frame_end) begin
          state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_tc) begin
          state_next = S_REPORT;
        end
      end
      S_REPORT: begin
        if (ack) begin
          state_next = S_LOAD;
        end
      end
      default: begin
        state_next = S_LOAD;
      end
    endcase
  end

  // Flag shift register: new bytes enter at the bottom so short frames stay right-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag <= '0;
    end else if (release_result) begin
      flag <= '0;
    end else if (accept) begin
      flag <= (flag << 8) | W'(in_data);
    end
  end

  // Byte counter; frame_end fires no later than NBYTES so it never exceeds NBYTES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
    end else if (release_result) begin
      byte_cnt <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt_inc;
    end
  end

  // Settle down-counter: loaded at frame end, parks at the terminal count of 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (frame_end) begin
      settle_cnt <= SW'(SETTLE);
    end else if ((state == S_SETTLE) && (settle_cnt != SW'(1))) begin
      settle_cnt <= settle_cnt - SW'(1);
    end
  end

  // Length error is captured at frame end and held through REPORT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_err <= 1'b0;
    end else if (release_result) begin
      len_err <= 1'b0;
    end else if (frame_end) begin
      len_err <= len_bad;
    end
  end

  // Result capture: wrong is sampled exactly once, at the settle terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
      pass <= 1'b0;
    end else if (release_result) begin
      done <= 1'b0;
      pass <= 1'b0;
    end else if (settle_tc) begin
      done <= 1'b1;
      pass <= (wrong == '0) && !len_err;
    end
  end

endmodule

// File: tb/tb_flag_loader.sv
// tb_flag_loader: directed frames against a stub checker, scoreboard-checked.
module tb_flag_loader;

  localparam int NB = 32;
  localparam int ST = 8;
  localparam logic [255:0] GOOD  = {40'h696374667b, 208'h0, 8'h7d};
  localparam logic [255:0] BADF  = {40'h696374667b, 8'h41, 200'h0, 8'h7d};
  localparam logic [255:0] SHORT = {216'h0, 40'h696374667b};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = 8'h00;
  logic         in_last = 1'b0;
  logic [255:0] flag;
  logic [255:0] wrong;
  logic         done;
  logic         pass;
  logic         len_err;
  logic         ack = 1'b0;

  typedef struct packed {
    logic         pass;
    logic         len_err;
    logic [255:0] flag;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] stim [0:31];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         term_cyc = 0;
  logic       done_q = 1'b0;

  assign wrong = flag ^ GOOD;

  flag_loader #(.NBYTES(NB), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .flag(flag), .wrong(wrong),
    .done(done), .pass(pass), .len_err(len_err), .ack(ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation each time done rises.
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got result with empty scoreboard");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pass", 256'(pass), 256'(e.pass));
        chk("len_err", 256'(len_err), 256'(e.len_err));
        chk("flag", flag, e.flag);
        chk("latency", 256'(cyc - term_cyc), 256'(ST));
      end
    end
    done_q <= done;
  end

  task automatic load_good();
    for (int i = 0; i < 32; i++) stim[i] = 8'h00;
    stim[0] = 8'h69; stim[1] = 8'h63; stim[2] = 8'h74;
    stim[3] = 8'h66; stim[4] = 8'h7b; stim[31] = 8'h7d;
  endtask

  task automatic send_frame(input int n, input bit last_final, input bit gap,
                            input bit push, input logic e_pass, input logic e_len,
                            input logic [255:0] e_flag);
    for (int i = 0; i < n; i++) begin
      bit acc;
      bit r;
      int k;
      in_valid = 1'b1;
      in_data  = stim[i];
      in_last  = (i == n - 1) && last_final;
      acc = 0;
      k = 0;
      while (!acc && k < 200) begin
        @(negedge clk);
        r = in_ready;
        @(posedge clk);
        #1;
        if (r) acc = 1;
        k++;
      end
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL byte_timeout: byte %0d not accepted within %0d cycles", i, k);
      end
      if (i == n - 1) begin
        term_cyc = cyc;
        if (push) sb.push_back('{pass: e_pass, len_err: e_len, flag: e_flag});
      end
      if (gap) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: done still %0b after %0d cycles", done, k);
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    chk("ack_done", 256'(done), 256'(0));
    chk("ack_flag", flag, 256'(0));
    chk("ack_ready", 256'(in_ready), 256'(1));
    chk("ack_len_err", 256'(len_err), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #12;
    chk("rst_ready", 256'(in_ready), 256'(1));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_pass", 256'(pass), 256'(0));
    chk("rst_len_err", 256'(len_err), 256'(0));
    chk("rst_flag", flag, 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Correct flag.
    load_good();
    send_frame(32, 1, 0, 1, 1'b1, 1'b0, GOOD);
    chk("settle_ready", 256'(in_ready), 256'(0));
    wait_done();
    do_ack();

    // Wrong flag: byte 6 = 41.
    load_good();
    stim[5] = 8'h41;
    send_frame(32, 1, 0, 1, 1'b0, 1'b0, BADF);
    wait_done();
    chk("wrong_bit207", 256'(wrong[207]), 256'(0));
    chk("wrong_nonzero", 256'(wrong != 256'(0)), 256'(1));
    do_ack();

    // Short frame of 5 bytes.
    load_good();
    send_frame(5, 1, 0, 1, 1'b0, 1'b1, SHORT);
    wait_done();
    do_ack();

    // Missing last; the next frame's first byte waits through REPORT and is not lost.
    load_good();
    send_frame(32, 0, 0, 1, 1'b0, 1'b1, GOOD);
    fork
      send_frame(32, 1, 0, 1, 1'b1, 1'b0, GOOD);
      begin
        wait_done();
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("held_off", 256'(in_ready), 256'(0));
        end
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
      end
    join
    wait_done();
    do_ack();

    // Gapped valid, ack during SETTLE ignored.
    load_good();
    send_frame(32, 1, 1, 1, 1'b1, 1'b0, GOOD);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    chk("settle_ack_ignored", 256'(done), 256'(0));
    wait_done();
    chk("report_hold_done", 256'(done), 256'(1));
    do_ack();

    // Async reset during SETTLE, then a clean frame.
    load_good();
    send_frame(32, 1, 0, 0, 1'b0, 1'b0, GOOD);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_flag", flag, 256'(0));
    chk("arst_done", 256'(done), 256'(0));
    chk("arst_ready", 256'(in_ready), 256'(1));
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    load_good();
    send_frame(32, 1, 0, 1, 1'b1, 1'b0, GOOD);
    wait_done();
    do_ack();

    repeat (ST + 4) @(posedge clk);
    #1;
    chk("sb_empty", 256'(sb.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
